// File: rtl/dxdt_pass_scheduler.sv
// dxdt_pass_scheduler
// Computes Y = D*X*D^T on one shared 8-wide row-times-matrix engine in two passes:
//   pass 0: rows of D against X   -> T buffer (wr_sel=0)
//   pass 1: rows of T against D^T -> Y        (wr_sel=1)
// Optional engine watchdog: define DXDT_TIMEOUT_EN (limit TIMEOUT_CYC cycles in RUN).
// All outputs are registered: they are decoded from the next state at each edge.
module dxdt_pass_scheduler #(
    parameter int ROW_W       = 152,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_rd_req,
    output logic             o_rd_sel,
    output logic [2:0]       o_rd_row,
    input  logic             i_rd_valid,
    input  logic [ROW_W-1:0] i_rd_data,
    output logic             o_eng_rst,
    output logic             o_eng_start,
    output logic             o_eng_bsel,
    output logic [ROW_W-1:0] o_eng_a,
    input  logic             i_eng_done,
    input  logic [ROW_W-1:0] i_eng_y,
    output logic             o_wr_en,
    output logic             o_wr_sel,
    output logic [2:0]       o_wr_row,
    output logic [ROW_W-1:0] o_wr_data
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ENG_RST = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
`ifdef DXDT_TIMEOUT_EN
    localparam logic [2:0] S_ERR     = 3'd6;
`endif

    logic [2:0]       r_state, w_nstate;
    logic [2:0]       r_row, w_nrow;
    logic             r_phase, w_nphase;
    logic             w_fault;
    logic             r_busy, r_done, r_rd_req, r_rd_sel;
    logic [2:0]       r_rd_row, r_wr_row;
    logic             r_eng_rst, r_eng_start, r_eng_bsel;
    logic             r_wr_en, r_wr_sel;
    logic [ROW_W-1:0] r_eng_a, r_wr_data;

`ifdef DXDT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_tmo;

    // The limit is reached on the edge where the count would become TIMEOUT_CYC.
    assign w_tmo   = (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_fault = (w_nstate == S_ERR);
    assign o_err   = r_err;

    // Cycles spent in RUN; held at zero elsewhere so each RUN entry starts from 0.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != S_RUN) r_cnt <= '0;
        else                             r_cnt <= r_cnt + 1'b1;
    end

    // Sticky timeout flag; cleared by reset or by the next accepted start.
    always_ff @(posedge i_clk) begin
        if (i_reset)                            r_err <= 1'b0;
        else if (r_state == S_IDLE && i_start)  r_err <= 1'b0;
        else if (w_fault)                       r_err <= 1'b1;
    end
`else
    assign w_fault = 1'b0;
    assign o_err   = 1'b0;
`endif

    // Next state plus row/pass counters; rd_valid and eng_done only matter in their own states.
    always_comb begin
        w_nstate = r_state;
        w_nrow   = r_row;
        w_nphase = r_phase;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nrow   = 3'd0;
                    w_nphase = 1'b0;
                    w_nstate = S_FETCH;
                end
            end
            S_FETCH:   if (i_rd_valid) w_nstate = S_ENG_RST;
            S_ENG_RST: w_nstate = S_RUN;
            S_RUN: begin
                if (i_eng_done) w_nstate = S_WRITE;
`ifdef DXDT_TIMEOUT_EN
                else if (w_tmo) w_nstate = S_ERR;
`endif
            end
            S_WRITE: begin
                if (r_row == 3'd7) begin
                    if (r_phase) begin
                        w_nstate = S_DONE;
                    end else begin
                        w_nrow   = 3'd0;
                        w_nphase = 1'b1;
                        w_nstate = S_FETCH;
                    end
                end else begin
                    w_nrow   = r_row + 3'd1;
                    w_nstate = S_FETCH;
                end
            end
            default: w_nstate = S_IDLE;  // DONE, ERR and unused encodings
        endcase
    end

    // State, counters and registered outputs decoded from the upcoming state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_row       <= 3'd0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_rd_row    <= 3'd0;
            r_eng_rst   <= 1'b1;
            r_eng_start <= 1'b0;
            r_eng_bsel  <= 1'b0;
            r_eng_a     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_wr_row    <= 3'd0;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_nstate;
            r_row       <= w_nrow;
            r_phase     <= w_nphase;
            r_busy      <= (w_nstate != S_IDLE);
            r_done      <= (w_nstate == S_DONE) || w_fault;
            r_eng_rst   <= (w_nstate == S_IDLE) || (w_nstate == S_ENG_RST);
            r_rd_req    <= (w_nstate == S_FETCH);
            r_rd_sel    <= (w_nstate == S_FETCH) && w_nphase;
            r_rd_row    <= (w_nstate == S_FETCH) ? w_nrow : 3'd0;
            r_eng_start <= (w_nstate == S_RUN);
            r_eng_bsel  <= (w_nstate == S_RUN) && w_nphase;
            r_wr_en     <= (w_nstate == S_WRITE);
            r_wr_sel    <= (w_nstate == S_WRITE) && w_nphase;
            r_wr_row    <= (w_nstate == S_WRITE) ? w_nrow : 3'd0;
            // Operand and result rows are cleared on return to IDLE so IDLE drives zeros.
            if (w_nstate == S_IDLE)                     r_eng_a <= '0;
            else if (r_state == S_FETCH && i_rd_valid)  r_eng_a <= i_rd_data;
            if (w_nstate == S_IDLE)                     r_wr_data <= '0;
            else if (r_state == S_RUN && i_eng_done)    r_wr_data <= i_eng_y;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_req    = r_rd_req;
    assign o_rd_sel    = r_rd_sel;
    assign o_rd_row    = r_rd_row;
    assign o_eng_rst   = r_eng_rst;
    assign o_eng_start = r_eng_start;
    assign o_eng_bsel  = r_eng_bsel;
    assign o_eng_a     = r_eng_a;
    assign o_wr_en     = r_wr_en;
    assign o_wr_sel    = r_wr_sel;
    assign o_wr_row    = r_wr_row;
    assign o_wr_data   = r_wr_data;
endmodule

// File: tb/tb_dxdt_pass_scheduler.sv
// Bench for dxdt_pass_scheduler: read-port and engine responders plus a matrix-level
// reference (T = D*X, Y = T*D^T) that predicts the 16 row writes and the run length.
module tb_dxdt_pass_scheduler;
`ifdef DXDT_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 1023;
`endif
    localparam int RW = 152;
    localparam int EW = 19;

    logic          i_clk = 1'b0, i_reset, i_start;
    logic          o_busy, o_done, o_err, o_rd_req, o_rd_sel;
    logic [2:0]    o_rd_row, o_wr_row;
    logic          i_rd_valid;
    logic [RW-1:0] i_rd_data, o_eng_a, i_eng_y, o_wr_data;
    logic          o_eng_rst, o_eng_start, o_eng_bsel, i_eng_done, o_wr_en, o_wr_sel;

    dxdt_pass_scheduler #(.ROW_W(RW), .TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_rd_req(o_rd_req), .o_rd_sel(o_rd_sel), .o_rd_row(o_rd_row),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
        .o_eng_rst(o_eng_rst), .o_eng_start(o_eng_start), .o_eng_bsel(o_eng_bsel),
        .o_eng_a(o_eng_a), .i_eng_done(i_eng_done), .i_eng_y(i_eng_y),
        .o_wr_en(o_wr_en), .o_wr_sel(o_wr_sel), .o_wr_row(o_wr_row), .o_wr_data(o_wr_data)
    );

    always #5 i_clk = ~i_clk;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Matrices: 0 = D, 1 = X, 2 = expected T, 3 = expected Y
    int M[4][8][8];
    logic [RW-1:0] tbuf[8];

    function automatic logic [RW-1:0] pack(input int m, input int r);
        logic [RW-1:0] y;
        y = '0;
        for (int j = 0; j < 8; j++) y[j*EW +: EW] = EW'(M[m][r][j]);
        return y;
    endfunction

    task automatic new_mats(input bit ident);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                M[0][r][c] = ident ? int'(r == c) : int'($urandom_range(3, 0));
                M[1][r][c] = ident ? r * 8 + c + 1 : int'($urandom_range(63, 0));
            end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                M[2][r][c] = 0;
                for (int k = 0; k < 8; k++) M[2][r][c] += M[0][r][k] * M[1][k][c];
            end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                M[3][r][c] = 0;
                for (int k = 0; k < 8; k++) M[3][r][c] += M[2][r][k] * M[0][c][k];
            end
    endtask

    // Row engine behaviour: a row times X (bsel=0) or D^T (bsel=1).
    function automatic logic [RW-1:0] eng_calc(input logic [RW-1:0] a, input logic bsel);
        logic [RW-1:0] y;
        int s;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int k = 0; k < 8; k++)
                s += int'(a[k*EW +: EW]) * (bsel ? M[0][j][k] : M[1][k][j]);
            y[j*EW +: EW] = EW'(s);
        end
        return y;
    endfunction

    // Environment configuration/state shared with the responders
    int  cfg_e = 10;
    bit  cfg_rnd = 0;
    bit  force_done = 0;
    int  d_sum = 0, hold_bad = 0;
    int  run_idx = 0, stall_idx = -1, run_entry_cyc = 0;

    typedef struct packed {logic sel; logic [2:0] row; logic [RW-1:0] data;} wr_t;
    wr_t wq[$];

    // Read port: rd_valid pulses d cycles after rd_req first rises; request must hold meanwhile.
    initial begin : rd_resp
        bit act; int age, d; logic s0; logic [2:0] r0;
        act = 0; age = 0; d = 1; s0 = 0; r0 = 0;
        i_rd_valid = 0; i_rd_data = '0;
        forever begin
            @(posedge i_clk); #1;
            if (o_rd_req !== 1'b1) act = 0;
            else if (!act) begin
                act = 1; age = 0;
                d = cfg_rnd ? int'($urandom_range(6, 1)) : 1;
                d_sum += d; s0 = o_rd_sel; r0 = o_rd_row;
            end else begin
                age++;
                if (o_rd_sel !== s0 || o_rd_row !== r0) hold_bad++;
            end
            i_rd_valid = act && age == d;
            if (i_rd_valid) i_rd_data = s0 ? tbuf[r0] : pack(0, int'(r0));
            else i_rd_data = RW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        end
    end

    // Engine: done E cycles after start rises, held until eng_rst.
    initial begin : eng_resp
        bit act; int age; logic ps, pr; logic [RW-1:0] res, a0;
        act = 0; age = 0; ps = 0; pr = 1; res = '0; a0 = '0;
        i_eng_done = 0; i_eng_y = '0;
        forever begin
            @(posedge i_clk); #1;
            if (o_eng_start === 1'b1 && ps !== 1'b1) begin
                chk("rst_before_start", 512'(pr), 512'(1'b1));
                run_idx++; run_entry_cyc = cyc;
            end
            if (o_eng_rst === 1'b1) act = 0;
            else if (o_eng_start === 1'b1 && !act) begin
                act = 1; age = 0; a0 = o_eng_a; res = eng_calc(o_eng_a, o_eng_bsel);
            end else if (act) begin
                age++;
                if (o_eng_start === 1'b1 && o_eng_a !== a0) hold_bad++;
            end
            i_eng_done = (act && age >= cfg_e && run_idx != stall_idx) ||
                         (force_done && o_eng_start !== 1'b1);
            i_eng_y = act ? res : RW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            ps = o_eng_start; pr = o_eng_rst;
        end
    end

    // Write monitor: log every strobe; T rows feed pass-1 reads.
    initial begin : wr_mon
        wr_t w;
        forever begin
            @(posedge i_clk); #1;
            if (o_wr_en === 1'b1) begin
                w.sel = o_wr_sel; w.row = o_wr_row; w.data = o_wr_data;
                wq.push_back(w);
                if (o_wr_sel === 1'b0) tbuf[o_wr_row] = o_wr_data;
            end
        end
    end

    function automatic wr_t exp_wr(input int i);
        wr_t w;
        w.sel  = (i >= 8);
        w.row  = 3'(i % 8);
        w.data = pack(i < 8 ? 2 : 3, i % 8);
        return w;
    endfunction

    function automatic wr_t got_wr(input int i);
        wr_t w;
        w = 'x;
        if (i < wq.size()) w = wq[i];
        return w;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_eng_rst"}, 512'(o_eng_rst), 512'(1'b1));
        chk({tag, "_others"}, 512'({o_busy, o_done, o_err, o_rd_req, o_rd_sel, o_rd_row,
                                    o_eng_start, o_eng_bsel, o_eng_a, o_wr_en, o_wr_sel,
                                    o_wr_row, o_wr_data}), '0);
    endtask

    int last_rel = 0;

    // One full run from IDLE; optional stray start pulses in cycles 5 and 241.
    task automatic run_chk(input string tag, input bit poke);
        int k, dc, nd;
        bit seen;
        logic b1, e1, ba;
        wq.delete(); d_sum = 0; hold_bad = 0;
        seen = 0; nd = 0; dc = 0; b1 = 0; e1 = 1; ba = 1'bx;
        i_start = 1; k = cyc;
        for (int n = 0; n < 4000; n++) begin
            @(posedge i_clk); #1;
            i_start = poke && ((cyc - k) == 5 || (cyc - k) == 241);
            if (cyc == k + 1) begin b1 = o_busy; e1 = o_err; end
            if (o_done === 1'b1) begin
                nd++;
                if (!seen) begin seen = 1; dc = cyc; end
            end
            if (seen && cyc == dc + 1) ba = o_busy;
            if (seen && cyc >= dc + 3) break;
        end
        i_start = 0;
        last_rel = dc - k;
        chk({tag, "_busy_first"}, 512'(b1), 512'(1'b1));
        chk({tag, "_err_cleared"}, 512'(e1), 512'(1'b0));
        chk_i({tag, "_done_seen"}, int'(seen), 1);
        chk_i({tag, "_run_cycles"}, dc - k, 1 + 16 * (cfg_e + 4) + d_sum);
        chk_i({tag, "_done_pulses"}, nd, 1);
        chk({tag, "_busy_after"}, 512'(ba), 512'(1'b0));
        chk_i({tag, "_hold_stable"}, hold_bad, 0);
        chk_i({tag, "_nwrites"}, wq.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_wr%0d", tag, i), 512'(got_wr(i)), 512'(exp_wr(i)));
    endtask

    initial begin : main
        bit found;
        i_reset = 1; i_start = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check_idle("reset_state");
        i_reset = 0;
        @(posedge i_clk); #1;
        check_idle("idle_after_reset");

        // Nominal: identity D, X = 1..64, d=1, E=10, stray starts in cycles 5 and 241
        new_mats(1); cfg_rnd = 0; cfg_e = 10;
        run_chk("nominal", 1);
        chk_i("nominal_done_cycle", last_rel, 241);

        // Random read latency per row, random matrices and engine latency
        for (int t = 0; t < 2; t++) begin
            new_mats(0); cfg_rnd = 1; cfg_e = int'($urandom_range(12, 2));
            run_chk($sformatf("rand%0d", t), 0);
        end

        // eng_done held high outside RUN: IDLE must stay put, then a run must be unaffected
        wq.delete(); force_done = 1;
        repeat (5) @(posedge i_clk);
        #1;
        chk("forced_idle_busy", 512'(o_busy), 512'(1'b0));
        chk_i("forced_idle_writes", wq.size(), 0);
        new_mats(0); cfg_rnd = 1; cfg_e = 4;
        run_chk("forced", 0);
        force_done = 0;

        // Reset in pass 1, row 3 fetch, then a fresh complete run
        new_mats(0); cfg_rnd = 1; cfg_e = 5;
        i_start = 1; found = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge i_clk); #1;
            i_start = 0;
            if (o_rd_req === 1'b1 && o_rd_sel === 1'b1 && o_rd_row === 3'd3) begin
                found = 1; break;
            end
        end
        chk_i("midrun_reach_p1r3", int'(found), 1);
        i_reset = 1;
        @(posedge i_clk); #1;
        check_idle("midrun_reset");
        i_reset = 0;
        new_mats(0); cfg_rnd = 1; cfg_e = 7;
        run_chk("after_reset", 0);

`ifdef DXDT_TIMEOUT_EN
        // Engine never completes on pass 0, row 2 (third engine start)
        begin : tmo
            int dc; bit seen; logic ev;
            new_mats(0); cfg_rnd = 0; cfg_e = 5;
            wq.delete(); run_idx = 0; stall_idx = 3;
            seen = 0; dc = 0; ev = 0;
            i_start = 1;
            for (int n = 0; n < 3000; n++) begin
                @(posedge i_clk); #1;
                i_start = 0;
                if (o_done === 1'b1) begin seen = 1; dc = cyc; ev = o_err; break; end
            end
            chk_i("tmo_done_seen", int'(seen), 1);
            chk("tmo_err", 512'(ev), 512'(1'b1));
            chk_i("tmo_delay", dc - run_entry_cyc, TO);
            chk_i("tmo_nwrites", wq.size(), 2);
            chk("tmo_wr0", 512'(got_wr(0)), 512'(exp_wr(0)));
            chk("tmo_wr1", 512'(got_wr(1)), 512'(exp_wr(1)));
            @(posedge i_clk); #1;
            chk("tmo_err_sticky", 512'(o_err), 512'(1'b1));
            chk("tmo_done_pulse", 512'(o_done), 512'(1'b0));
            stall_idx = -1;
            run_chk("after_tmo", 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
